master_decoder: RTL and testbench
=================================

# master_decoder

AHB-Lite address decoder and default slave for one master port of the multilayer interconnect; sits directly upstream of the master-side response mux. It decodes the master's address-phase HADDR into per-slave HSEL and registers the one-hot data-phase select that steers the response mux. It also implements the default slave, which answers unmapped accesses with a two-cycle ERROR response and logs them.

## Interface
- NUM_SLAVES, 2, number of mapped slaves.
- ADDR_WIDTH, 32, HADDR width.
- BASE_ADDR, {32'h1000_0000, 32'h0000_0000}, flattened NUM_SLAVES×ADDR_WIDTH base addresses; slave i at slice i.
- ADDR_MASK, {32'hF000_0000, 32'hF000_0000}, flattened masks; the region of slave i is where (addr & mask_i) == base_i.

- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_mhaddr  in  ADDR_WIDTH  master HADDR (address phase).
- i_mhtrans  in  2  master HTRANS; bit 1 set = NONSEQ/SEQ.
- i_mhready  in  1  HREADY fed back from the response mux output.
- o_hsel_addr  out  NUM_SLAVES  address-phase HSEL to the slaves, combinational.
- o_hsel_data  out  NUM_SLAVES+1  registered one-hot data-phase select to the response mux; bit NUM_SLAVES = default slave.
- o_dhreadyout  out  1  default-slave HREADYOUT; the mux consumes it at index NUM_SLAVES.
- o_dhresp  out  1  default-slave HRESP, 1 = ERROR. The default slave's HRDATA is tied to 0 at the top level.
- o_err_count  out  16  saturating count of unmapped active transfers.
- o_err_addr  out  ADDR_WIDTH  address of the most recent unmapped active transfer.

## Operation
- Decode is combinational: match[i] = ((i_mhaddr & mask_i) == base_i).
  - Overlapping regions: the lowest index wins, so o_hsel_addr is always one-hot or zero.
  - nomatch = ~|o_hsel_addr.
- Data-phase select register sel_q drives o_hsel_data.
  - It loads {nomatch, o_hsel_addr} on a clock edge where i_mhready=1.
  - It holds while i_mhready=0 (wait state), even if the address changes.
  - HTRANS does not qualify sel_q; an IDLE to unmapped space still selects the default slave.
- The default-slave FSM has three states.
  - IDLE: o_dhreadyout=1, o_dhresp=0.
  - ERR1: o_dhreadyout=0, o_dhresp=1.
  - ERR2: o_dhreadyout=1, o_dhresp=1.
- An "error start" is a clock edge with i_mhready=1, nomatch=1 and i_mhtrans[1]=1.
- FSM transitions:
  - IDLE → ERR1 on error start; otherwise stay in IDLE.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → ERR1 on error start (back-to-back errors); otherwise → IDLE.
- On each error start, o_err_addr is loaded with i_mhaddr and o_err_count is incremented. The count saturates at 16'hFFFF.
- Reset values (asynchronous, immediate on i_rst_n=0):
  - o_hsel_data = one-hot bit NUM_SLAVES, i.e. 3'b100 for the default configuration. The default slave is selected and idle so HREADY=1 and the bus cannot deadlock.
  - FSM = IDLE, so o_dhreadyout=1 and o_dhresp=0.
  - o_err_count=0 and o_err_addr=0.
  - o_hsel_addr follows the inputs.
- Reset asserted during ERR1/ERR2 aborts the error; outputs take their reset values in the same cycle.

## Timing
- o_hsel_addr: zero latency from i_mhaddr.
- o_hsel_data: updates on the first rising edge where i_mhready=1 after the address phase, i.e. one cycle after a zero-wait address phase.
- Unmapped active transfer: data phase lasts exactly 2 cycles, (ready=0, resp=1) then (ready=1, resp=1).
- Unmapped IDLE/BUSY: zero-wait OKAY.
- o_err_count and o_err_addr are visible the cycle after the error start (same edge as the ERR1 entry).

## Test plan
- Reset release → o_hsel_data=3'b100, o_dhreadyout=1, o_dhresp=0, o_err_count=0, o_err_addr=0.
- NONSEQ to 32'h1000_0004 with i_mhready=1 → o_hsel_addr=2'b10 in the same cycle; o_hsel_data=3'b010 in the next cycle.
- Address changes to 32'h0000_0000 while i_mhready=0 for 3 cycles → o_hsel_data holds 3'b010; it becomes 3'b001 one edge after i_mhready returns to 1.
- NONSEQ to 32'h8000_0000 → next cycle o_hsel_data=3'b100, ready=0, resp=1; following cycle ready=1, resp=1; o_err_count=1, o_err_addr=32'h8000_0000.
- IDLE to 32'h8000_0000 → default slave selected, ready=1, resp=0, count unchanged.
- Two back-to-back NONSEQs to unmapped space → FSM sequence ERR1, ERR2, ERR1, ERR2, and o_err_count=2.
- Async reset pulsed during ERR1 → immediate ready=1, resp=0, count=0, o_hsel_data=3'b100.
- Count preloaded near saturation, then one more error → o_err_count stays at 16'hFFFF.

Source files
------------

// File: rtl/master_decoder.sv
// AHB-Lite address decoder for one master port, with the registered data-phase
// select for the response mux and a default slave that errors unmapped transfers.
module master_decoder #(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDR = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASK = {32'hF000_0000, 32'hF000_0000}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_mhaddr,
    input  logic [1:0]            i_mhtrans,
    input  logic                  i_mhready,
    output logic [NUM_SLAVES-1:0] o_hsel_addr,
    output logic [NUM_SLAVES:0]   o_hsel_data,
    output logic                  o_dhreadyout,
    output logic                  o_dhresp,
    output logic [15:0]           o_err_count,
    output logic [ADDR_WIDTH-1:0] o_err_addr
);

    localparam int unsigned SEL_W = NUM_SLAVES + 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(1) << NUM_SLAVES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    logic [NUM_SLAVES-1:0] hsel_c;
    logic                  found_c;
    logic                  nomatch_c;
    logic                  err_start_c;
    logic [SEL_W-1:0]      sel_q;
    state_t                state_q;
    state_t                state_d;
    logic                  ready_d;
    logic                  resp_d;

    // Priority decode: the lowest matching slave index wins on overlap.
    always_comb begin
        hsel_c  = '0;
        found_c = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found_c &&
                ((i_mhaddr & ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hsel_c[i] = 1'b1;
                found_c   = 1'b1;
            end
        end
    end

    assign o_hsel_addr = hsel_c;
    assign nomatch_c   = ~|hsel_c;
    assign err_start_c = i_mhready & nomatch_c & i_mhtrans[1];
    assign o_hsel_data = sel_q;

    // Data-phase select follows the address phase only when the bus advances.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_q <= SEL_RST;
        end else if (i_mhready) begin
            sel_q <= {nomatch_c, hsel_c};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            o_dhreadyout <= 1'b1;
            o_dhresp     <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_dhreadyout <= ready_d;
            o_dhresp     <= resp_d;
        end
    end

    // Default-slave response: two-cycle ERROR, outputs precomputed from next state.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b1;
        resp_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (err_start_c) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_start_c ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_ERR1: begin
                ready_d = 1'b0;
                resp_d  = 1'b1;
            end
            ST_ERR2: resp_d = 1'b1;
            default: ;
        endcase
    end

    // Error log: last unmapped address and a saturating event count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_count <= '0;
            o_err_addr  <= '0;
        end else if (err_start_c) begin
            o_err_addr <= i_mhaddr;
            if (o_err_count != '1) begin
                o_err_count <= o_err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_master_decoder.sv
// Directed, table-driven bench for master_decoder in its default configuration.
module tb_master_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] mhaddr;
    logic [1:0]  mhtrans;
    logic        mhready;
    logic [1:0]  hsel_addr;
    logic [2:0]  hsel_data;
    logic        dhreadyout;
    logic        dhresp;
    logic [15:0] err_count;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    master_decoder dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mhaddr    (mhaddr),
        .i_mhtrans   (mhtrans),
        .i_mhready   (mhready),
        .o_hsel_addr (hsel_addr),
        .o_hsel_data (hsel_data),
        .o_dhreadyout(dhreadyout),
        .o_dhresp    (dhresp),
        .o_err_count (err_count),
        .o_err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        ready;
        logic [1:0]  e_hsel_addr;
        logic [2:0]  e_hsel_data;
        logic        e_rdy;
        logic        e_resp;
        logic [15:0] e_cnt;
        logic [31:0] e_eaddr;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hsel_data"}, 32'(hsel_data), 32'h4);
        check({tag, "_ready"},     32'(dhreadyout), 32'h1);
        check({tag, "_resp"},      32'(dhresp), 32'h0);
        check({tag, "_count"},     32'(err_count), 32'h0);
        check({tag, "_err_addr"},  err_addr, 32'h0);
    endtask

    initial begin
        vec_t v;
        // addr, trans, ready, hsel_addr, hsel_data, rdy, resp, count, err_addr
        vecs[0]  = '{32'h1000_0004, 2'b10, 1'b1, 2'b10, 3'b010, 1'b1, 1'b0, 16'd0, 32'h0};
        vecs[1]  = '{32'h0000_0000, 2'b10, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0, 16'd0, 32'h0};
        vecs[2]  = '{32'h0000_0000, 2'b10, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0, 16'd0, 32'h0};
        vecs[3]  = '{32'h0000_0000, 2'b10, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0, 16'd0, 32'h0};
        vecs[4]  = '{32'h0000_0000, 2'b10, 1'b1, 2'b01, 3'b001, 1'b1, 1'b0, 16'd0, 32'h0};
        vecs[5]  = '{32'h8000_0000, 2'b10, 1'b1, 2'b00, 3'b100, 1'b0, 1'b1, 16'd1, 32'h8000_0000};
        vecs[6]  = '{32'h0000_0000, 2'b00, 1'b0, 2'b01, 3'b100, 1'b1, 1'b1, 16'd1, 32'h8000_0000};
        vecs[7]  = '{32'h8000_0000, 2'b00, 1'b1, 2'b00, 3'b100, 1'b1, 1'b0, 16'd1, 32'h8000_0000};
        vecs[8]  = '{32'h9000_0000, 2'b11, 1'b1, 2'b00, 3'b100, 1'b0, 1'b1, 16'd2, 32'h9000_0000};
        vecs[9]  = '{32'hA000_0000, 2'b10, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1, 16'd2, 32'h9000_0000};
        vecs[10] = '{32'hA000_0000, 2'b10, 1'b1, 2'b00, 3'b100, 1'b0, 1'b1, 16'd3, 32'hA000_0000};
        vecs[11] = '{32'h1000_0000, 2'b10, 1'b0, 2'b10, 3'b100, 1'b1, 1'b1, 16'd3, 32'hA000_0000};
        vecs[12] = '{32'h1000_0000, 2'b10, 1'b1, 2'b10, 3'b010, 1'b1, 1'b0, 16'd3, 32'hA000_0000};

        rst_n   = 1'b0;
        mhaddr  = 32'h0;
        mhtrans = 2'b00;
        mhready = 1'b1;
        #22;
        rst_n = 1'b1;
        #1;
        check_reset_vals("reset");

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            mhaddr  = v.addr;
            mhtrans = v.trans;
            mhready = v.ready;
            #1;
            check($sformatf("v%0d_hsel_addr", i), 32'(hsel_addr), 32'(v.e_hsel_addr));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_hsel_data", i), 32'(hsel_data), 32'(v.e_hsel_data));
            check($sformatf("v%0d_ready", i),     32'(dhreadyout), 32'(v.e_rdy));
            check($sformatf("v%0d_resp", i),      32'(dhresp), 32'(v.e_resp));
            check($sformatf("v%0d_count", i),     32'(err_count), 32'(v.e_cnt));
            check($sformatf("v%0d_err_addr", i),  err_addr, v.e_eaddr);
        end

        // Async reset in the middle of ERR1 must abort the error immediately.
        mhaddr  = 32'hC000_0010;
        mhtrans = 2'b10;
        mhready = 1'b1;
        @(posedge clk);
        #1;
        check("err1_ready", 32'(dhreadyout), 32'h0);
        check("err1_resp",  32'(dhresp), 32'h1);
        check("err1_count", 32'(err_count), 32'd4);
        mhtrans = 2'b00;
        mhready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #1;
        rst_n = 1'b1;

        // Continuous unmapped NONSEQ with HREADY high starts an error every edge.
        mhaddr  = 32'h8000_0000;
        mhtrans = 2'b10;
        mhready = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 32'(err_count), 32'h0000_FFFE);
        @(posedge clk);
        #1;
        check("sat_ffff", 32'(err_count), 32'h0000_FFFF);
        repeat (2) @(posedge clk);
        #1;
        check("sat_hold", 32'(err_count), 32'h0000_FFFF);
        check("sat_addr", err_addr, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
